// File: rtl/subcarrier_sequencer_if.sv
// ---------------------------------------------------------------------------
// subcarrier_sequencer_if
//
// Purpose:
//   Bundles the two streaming links around the subcarrier sequencer:
//   the coded-bit input stream from the interleaver and the per-bin
//   control/data stream into the constellation mapper.
//
// Signals:
//   in_data         [5:0]  coded-bit group, LSB-aligned (interleaver -> seq)
//   in_valid               in_data valid                (interleaver -> seq)
//   in_ready               group consumed on valid&&ready (seq -> interleaver)
//   en                     output valid / mapper enable (seq -> mapper)
//   out_ready              mapper accepts current output (mapper -> seq)
//   data_in         [5:0]  masked bit group              (seq -> mapper)
//   bpsc            [2:0]  coded bits per subcarrier     (seq -> mapper)
//   is_zero                current bin is a null         (seq -> mapper)
//   is_pilot               current bin is a pilot        (seq -> mapper)
//   pilot_indicator        1 = pilot +1, 0 = pilot -1    (seq -> mapper)
//   sc_idx          [5:0]  current IFFT bin index        (seq -> mapper)
//
// Modports:
//   master : the sequencer (drives in_ready and the whole mapper bus)
//   slave  : the surrounding datapath (interleaver source + mapper sink)
// ---------------------------------------------------------------------------
interface subcarrier_sequencer_if;
    logic [5:0] in_data;
    logic       in_valid;
    logic       in_ready;

    logic       en;
    logic       out_ready;
    logic [5:0] data_in;
    logic [2:0] bpsc;
    logic       is_zero;
    logic       is_pilot;
    logic       pilot_indicator;
    logic [5:0] sc_idx;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output en,
        input  out_ready,
        output data_in,
        output bpsc,
        output is_zero,
        output is_pilot,
        output pilot_indicator,
        output sc_idx
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  en,
        output out_ready,
        input  data_in,
        input  bpsc,
        input  is_zero,
        input  is_pilot,
        input  pilot_indicator,
        input  sc_idx
    );
endinterface

// File: rtl/subcarrier_sequencer.sv
// ---------------------------------------------------------------------------
// subcarrier_sequencer
//
// Purpose:
//   Walks one 64-bin OFDM symbol at a time in IFFT bin order (0..63) for a
//   frame of num_sym symbols. Null bins (DC and guard band, 0 and 27..37)
//   and pilot bins (7, 21, 43, 57) are generated locally; every other bin
//   pulls one coded-bit group from the interleaver. Pilot polarity follows
//   the 127-length pilot scrambler (x^7 + x^4 + 1, all-ones seed), stepping
//   once per symbol. Each bin is presented to the mapper through a single
//   registered valid/ready stage.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   frame_start_i  one-cycle frame start pulse, honoured only when idle
//   num_sym_i      symbols in the frame, latched at frame start
//   bpsc_in_i      coded bits per subcarrier (1, 2, 4, 6), latched at start
//   sc_bus         master side of subcarrier_sequencer_if (input stream,
//                  mapper control/data stream)
//   busy_o         high while a frame is running
//   done_o         one-cycle pulse after the frame's last bin is accepted
//
// Parameters:
//   NSYM_W         width of the per-frame symbol count
// ---------------------------------------------------------------------------
module subcarrier_sequencer #(
    parameter int NSYM_W = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start_i,
    input  logic [NSYM_W-1:0]             num_sym_i,
    input  logic [2:0]                    bpsc_in_i,
    subcarrier_sequencer_if.master        sc_bus,
    output logic                          busy_o,
    output logic                          done_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic [6:0] LFSR_SEED  = 7'b111_1111;
    localparam logic [5:0] LAST_BIN   = 6'd63;
    localparam logic [5:0] INV_PILOT  = 6'd21;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e              state_q,   state_d;
    logic [5:0]          bin_q,     bin_d;
    logic [NSYM_W-1:0]   sym_q,     sym_d;
    logic [NSYM_W-1:0]   num_sym_q, num_sym_d;
    logic [2:0]          bpsc_q,    bpsc_d;
    logic [6:0]          lfsr_q,    lfsr_d;
    logic                done_q,    done_d;

    // Output stage registers
    logic                en_q,      en_d;
    logic [5:0]          data_q,    data_d;
    logic                zero_q,    zero_d;
    logic                pilot_q,   pilot_d;
    logic                pind_q,    pind_d;
    logic [5:0]          idx_q,     idx_d;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic       bin_null;
    logic       bin_pilot;
    logic       bin_data;
    logic [5:0] bit_mask;
    logic       pilot_p;
    logic       adv;
    logic       issuing;
    logic       load;
    logic       last_hs;

    // Classify the bin that is next to be loaded.
    always_comb begin : classify
        bin_null  = (bin_q == 6'd0) || ((bin_q >= 6'd27) && (bin_q <= 6'd37));
        bin_pilot = (bin_q == 6'd7)  || (bin_q == 6'd21) ||
                    (bin_q == 6'd43) || (bin_q == 6'd57);
        bin_data  = !bin_null && !bin_pilot;
    end

    // Unsupported modulation orders pass no bits at all.
    always_comb begin : mask_sel
        case (bpsc_q)
            3'd1:    bit_mask = 6'b000001;
            3'd2:    bit_mask = 6'b000011;
            3'd4:    bit_mask = 6'b001111;
            3'd6:    bit_mask = 6'b111111;
            default: bit_mask = 6'b000000;
        endcase
    end

    // Scrambler output for the current symbol.
    assign pilot_p = lfsr_q[6] ^ lfsr_q[3];

    // The output stage can take a new bin when it is empty or being drained.
    assign adv = !en_q || sc_bus.out_ready;

    // The symbol counter reaching num_sym means every bin of the frame has
    // been loaded; the frame then only waits for its last bin to drain.
    assign issuing = (state_q == S_RUN) && (sym_q != num_sym_q);

    assign sc_bus.in_ready = issuing && adv && bin_data;

    // Data bins stall (bubble) without input; null/pilot bins never wait.
    assign load = issuing && adv && (!bin_data || sc_bus.in_valid);

    // Once issuing has stopped, the only bin still pending is bin 63 of the
    // last symbol, so its handshake closes the frame.
    assign last_hs = (state_q == S_RUN) && !issuing && en_q &&
                     sc_bus.out_ready && (idx_q == LAST_BIN);

    // -----------------------------------------------------------------------
    // Next-state / output-stage logic
    // -----------------------------------------------------------------------
    always_comb begin : next_state
        // NOTE: every _d is given its hold value first, so no branch can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        bin_d     = bin_q;
        sym_d     = sym_q;
        num_sym_d = num_sym_q;
        bpsc_d    = bpsc_q;
        lfsr_d    = lfsr_q;
        done_d    = 1'b0;
        en_d      = en_q;
        data_d    = data_q;
        zero_d    = zero_q;
        pilot_d   = pilot_q;
        pind_d    = pind_q;
        idx_d     = idx_q;

        case (state_q)
            S_IDLE: begin
                if (frame_start_i) begin
                    if (num_sym_i != '0) begin
                        state_d   = S_RUN;
                        num_sym_d = num_sym_i;
                        bpsc_d    = bpsc_in_i;
                        lfsr_d    = LFSR_SEED;
                        bin_d     = '0;
                        sym_d     = '0;
                    end else begin
                        // Empty frame: nothing to send, report completion.
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (last_hs) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Output stage: en follows whether a bin was loaded this cycle;
        // while stalled (adv=0) everything holds.
        if (adv) begin
            en_d = load;
        end

        if (load) begin
            idx_d   = bin_q;
            zero_d  = bin_null;
            pilot_d = bin_pilot;
            // Bin 21 carries the inverted pilot.
            pind_d  = bin_pilot & ~(pilot_p ^ (bin_q == INV_PILOT));
            data_d  = bin_data ? (sc_bus.in_data & bit_mask) : 6'b000000;
            bin_d   = bin_q + 6'd1;   // wraps 63 -> 0
            if (bin_q == LAST_BIN) begin
                sym_d  = sym_q + NSYM_W'(1);
                lfsr_d = {lfsr_q[5:0], pilot_p};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            sym_q     <= '0;
            num_sym_q <= '0;
            bpsc_q    <= '0;
            lfsr_q    <= LFSR_SEED;
            done_q    <= 1'b0;
            en_q      <= 1'b0;
            data_q    <= '0;
            zero_q    <= 1'b0;
            pilot_q   <= 1'b0;
            pind_q    <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            sym_q     <= sym_d;
            num_sym_q <= num_sym_d;
            bpsc_q    <= bpsc_d;
            lfsr_q    <= lfsr_d;
            done_q    <= done_d;
            en_q      <= en_d;
            data_q    <= data_d;
            zero_q    <= zero_d;
            pilot_q   <= pilot_d;
            pind_q    <= pind_d;
            idx_q     <= idx_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign sc_bus.en              = en_q;
    assign sc_bus.data_in         = data_q;
    assign sc_bus.bpsc            = bpsc_q;
    assign sc_bus.is_zero         = zero_q;
    assign sc_bus.is_pilot        = pilot_q;
    assign sc_bus.pilot_indicator = pind_q;
    assign sc_bus.sc_idx          = idx_q;

    assign busy_o = (state_q == S_RUN);
    assign done_o = done_q;

endmodule

// File: doc/subcarrier_sequencer.md
Name: subcarrier_sequencer

Overview:
Upstream neighbour of the constellation mapper. Sequences one 64-subcarrier OFDM symbol at a time in IFFT bin order (bin 0..63). Inserts nulls (DC and guard band) and pilots, with per-symbol pilot polarity from the 127-length 802.11a pilot scrambler. Pulls one coded-bit group per data subcarrier from the interleaver and drives the mapper's control and data inputs through a registered valid/ready stage.

Parameters:
NSYM_W, 12, width of the per-frame OFDM symbol count.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse starting a frame; honoured only in IDLE
num_sym  in  NSYM_W  symbols in the frame; latched at frame_start
bpsc_in  in  3  coded bits per subcarrier (1, 2, 4, 6); latched at frame_start
in_data  in  6  coded-bit group, LSB-aligned, from the interleaver
in_valid  in  1  in_data valid
in_ready  out  1  group consumed when in_valid && in_ready
en  out  1  output valid; drives the mapper en
out_ready  in  1  downstream accepts the current output
data_in  out  6  masked bit group to the mapper
bpsc  out  3  latched bpsc
is_zero  out  1  current bin is null
is_pilot  out  1  current bin is a pilot
pilot_indicator  out  1  1 = pilot +1, 0 = pilot -1
sc_idx  out  6  current bin index
busy  out  1  state == RUN
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; all outputs 0; bin counter and symbol counter cleared; pilot LFSR s[6:0]=7'b1111111. Reset mid-frame aborts the frame immediately with no done pulse.
- States:
  - IDLE: on frame_start with num_sym!=0, latch num_sym and bpsc_in, reset LFSR to all-ones, bin=0, go to RUN. On frame_start with num_sym==0, stay in IDLE and pulse done on the next cycle.
  - RUN: frame_start is ignored.
- Output register advance condition: adv = !en || out_ready. Outputs hold stable while en && !out_ready.
- Bin classes:
  - null: bins 0 and 27..37.
  - pilot: bins 7, 21, 43, 57.
  - data: all other bins (48 per symbol).
- Per cycle in RUN with adv=1:
  - Null or pilot bin: load outputs, en=1. Input is not consumed.
  - Data bin: in_ready=adv (combinational). If in_valid, load outputs with en=1. If !in_valid, en=0 (bubble) and the bin does not advance.
  - In both cases bin increments on load.
- in_ready is 0 in IDLE, on null/pilot bins, and when adv=0.
- Output fields on load:
  - sc_idx = bin.
  - is_zero = null class; is_pilot = pilot class.
  - data_in = in_data & mask for data bins, else 0. Masks: bpsc 1→000001, 2→000011, 4→001111, 6→111111, any other value→000000.
- Pilot polarity:
  - p = s[6]^s[3] (LFSR x^7+x^4+1).
  - pilot_indicator = ~(p ^ (bin==21)), i.e. bin 21 (k=+21) is inverted.
  - pilot_indicator = 0 on non-pilot bins.
  - LFSR shifts once per symbol, {s[5:0],p}, when bin 63 is loaded. With the all-ones seed, symbols 0..7 give polarity +,+,+,+,-,-,-,+.
- Bin 63 load: bin wraps to 0 and the symbol counter increments.
- Frame end: the handshake (en && out_ready) of bin 63 of the last symbol returns the state to IDLE and pulses done on the following cycle. en drops unless another output is pending (none in IDLE).
- Latency: data accepted at edge t appears on outputs after edge t (registered). frame_start at edge t gives the first output (bin 0, is_zero=1) valid after edge t+1.
- Throughput: one bin per cycle with in_valid and out_ready held high; 64 cycles per symbol.

Test Plan:
- Reset, then frame_start with num_sym=1, bpsc_in=2, in_valid=1, out_ready=1, in_data=0..47 → 64 consecutive en cycles. is_zero at bins 0 and 27..37. Pilots at 7, 43, 57 with pilot_indicator=1; bin 21 with pilot_indicator=0. Exactly 48 in_ready handshakes. done pulses 1 cycle after the bin-63 handshake.
- num_sym=8, bpsc 6 → pilot_indicator at bin 7 across symbols = 1,1,1,1,0,0,0,1; bin 21 shows the complement.
- bpsc_in=4 with in_data=6'b110101 → data_in=6'b000101. bpsc_in=3 → data_in=0 on all data bins.
- out_ready toggled 1/0 every cycle → outputs held stable while stalled, no input consumed during stalls, no bin skipped or duplicated, 128 cycles per symbol.
- in_valid low at bin 5 for 3 cycles → en=0 for 3 cycles; bin 5 is then emitted with the correct data.
- rst asserted at bin 30 of symbol 2 → next cycle all outputs 0, state IDLE, no done. A new frame_start restarts with LFSR seed all-ones (symbol-0 polarity +).
